ucode_mul_seq: RTL
==================

Name: ucode_mul_seq

Overview:
- Parametrised next-generation microcode multiply sequencer in the decode/fetch path.
- On a decoded MUL/MULS, it takes over the instruction mux and injects MOV/ADD/ADDS/SUB/SUBI/NOT micro-ops that compute R_dest = R_source × multiplier. It then returns control to fetch and restores the pre-MUL flags.
- New over the prior generation:
  - counter width is configurable;
  - the pipeline can stall it and flush it;
  - start uses a ready/valid handshake;
  - dest==source aliasing is handled safely through a scratch register.

Parameters:
CNT_W, 32, width of the iteration counter and of the sign-extended multiplier
REG_W, 4, register-address width
SCRATCH_REG, 15, register clobbered when dest_reg==source_reg
NOP_INSTR, {5'b11001,27'b0}, instruction emitted when not injecting

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start_mul  in  1  decoded MUL valid
mul_ready  out  1  high when idle; start accepted on start_mul && mul_ready
mul_type  in  2  0=MULI, 1=MULR, 2=MULSI, 3=MULSR
dest_reg  in  REG_W  R_dest
source_reg  in  REG_W  R_source
immediate  in  16  multiplier for MULI/MULSI (two's complement)
readDataSecond  in  CNT_W  multiplier for MULR/MULSR (two's complement)
flags_in  in  4  flags at acceptance
stall  in  1  pipeline cannot take an instruction this cycle
flush  in  1  abort the current sequence
output_instruction  out  32  injected micro-op
mux_ctrl  out  1  output_instruction valid; selects the sequencer at the IF mux
mul_release  out  1  one-cycle pulse when the sequence completes
flags_back_out  out  4  captured flags; valid while mul_release=1
busy  out  1  not idle

Behaviour:
- Reset (rst=0, async): state=IDLE, all counters and captures cleared.
  - Outputs: mul_ready=1, mux_ctrl=0, output_instruction=NOP_INSTR, mul_release=0, flags_back_out=0, busy=0.
- Acceptance (start_mul && mul_ready): the following are latched.
  - Latched values: type, dest, source, flags_in, neg flag, and cnt = |m|.
  - m is the immediate sign-extended to CNT_W (types 0,2) or readDataSecond (types 1,3).
  - |−2^(CNT_W−1)| = 2^(CNT_W−1), held as unsigned.
- Instruction encodings:
  - R-type {op7, rd, rn, rm, 13'b0}; MOV {0000000, rd, 5'b0, 16'b0}; SUBI {0010010, rd, rn, 1'b0, 16'd1}; NOT {0110110, rd, rn, 17'b0}.
  - Opcodes: ADD=0110001, ADDS=0111001 (types 2,3 use ADDS), SUB=0110010.
- States and emitted instructions (each has mux_ctrl=1):
  - IDLE → CLEAR if cnt==0.
  - IDLE → COPY0 if dest==source.
  - IDLE → MOV otherwise.
  - CLEAR: emit SUB rd,rd,rd → HALT.
  - COPY0: emit SUB S,S,S (S=SCRATCH_REG) → COPY1.
  - COPY1: emit ADD S,S,src; effective source becomes S → MOV.
  - MOV: emit MOV rd,#0 → ADD.
  - ADD: emit ADD/ADDS rd,rd,effsrc; cnt−=1. Exits when the decremented cnt==0:
    - to FIX_SUB if neg;
    - to HALT otherwise.
  - FIX_SUB: emit SUBI rd,rd,#1 → FIX_NOT.
  - FIX_NOT: emit NOT rd,rd → HALT.
  - HALT: mux_ctrl=0, emit NOP, mul_release=1, flags_back_out=captured flags → IDLE.
- Stall:
  - While stall=1 in any injecting state, output_instruction and mux_ctrl hold.
  - State and cnt do not change; the held instruction is consumed on the first cycle with stall=0.
  - HALT ignores stall.
- Flush:
  - flush=1 in any non-IDLE state → IDLE next cycle, with no mul_release and flags_back_out unchanged.
  - Flush has priority over stall and over start.
  - The cycle that sees flush still drives its current outputs.
- Simultaneous start_mul in a non-IDLE state is ignored; the decoder must hold it until mul_ready.
- Instruction count:
  - cnt==0: exactly 1.
  - Otherwise: 1 (MOV) + cnt (ADD) + 2·neg + 2·(dest==source).
- Latency from acceptance to mul_release = instruction count + 1 cycles, with no stalls.
- Operands (dest_reg, immediate, etc.) are sampled only at acceptance; later changes have no effect.
- No arithmetic is performed beyond the cnt decrement and the magnitude negate.

Test Plan:
- MULI R1,R0,#3, no stall → MOV R1; ADD R1,R1,R0 ×3; release on cycle 5. flags_back_out equals flags_in captured at start.
- MULSI R2,R3,#−2 → MOV; ADDS ×2; SUBI R2,R2,#1; NOT R2,R2; release; total 5 injected.
- MULR R4,R4 with readDataSecond=2 → SUB R15×3; ADD R15,R15,R4; MOV R4; ADD R4,R4,R15 ×2.
- MULI immediate=0 → single SUB R1,R1,R1, then release; a 3-cycle stall mid-ADD holds the same instruction and ADD count is unchanged.
- Flush asserted on the 2nd ADD of MULI #5 → IDLE next cycle, no mul_release, mul_ready=1; next MUL runs correctly.
- Reset deasserted mid-sequence after assertion → all outputs at reset values.

Source files
------------

// File: rtl/ucode_mul_seq.sv
// rtl/ucode_mul_seq.sv - microcode multiply sequencer injecting MOV/ADD/SUB/NOT micro-ops
module ucode_mul_seq #(
    parameter int          CNT_W       = 32,
    parameter int          REG_W       = 4,
    parameter int          SCRATCH_REG = 15,
    parameter logic [31:0] NOP_INSTR   = {5'b11001, 27'b0}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mul,
    output logic             mul_ready,
    input  logic [1:0]       mul_type,
    input  logic [REG_W-1:0] dest_reg,
    input  logic [REG_W-1:0] source_reg,
    input  logic [15:0]      immediate,
    input  logic [CNT_W-1:0] readDataSecond,
    input  logic [3:0]       flags_in,
    input  logic             stall,
    input  logic             flush,
    output logic [31:0]      output_instruction,
    output logic             mux_ctrl,
    output logic             mul_release,
    output logic [3:0]       flags_back_out,
    output logic             busy
);

    // Opcodes of the injected micro-ops
    localparam logic [6:0] OP_MOV  = 7'b0000000;
    localparam logic [6:0] OP_ADD  = 7'b0110001;
    localparam logic [6:0] OP_ADDS = 7'b0111001;
    localparam logic [6:0] OP_SUB  = 7'b0110010;
    localparam logic [6:0] OP_SUBI = 7'b0010010;
    localparam logic [6:0] OP_NOT  = 7'b0110110;

    // Register fields in the instruction word are four bits wide
    localparam logic [3:0] SCR_FLD = 4'(SCRATCH_REG);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_COPY0,
        S_COPY1,
        S_MOV,
        S_ADD,
        S_FIX_SUB,
        S_FIX_NOT,
        S_HALT
    } state_t;

    // Sequencer state and operands captured at acceptance
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] dest_q, dest_d;
    logic [REG_W-1:0] src_q, src_d;
    logic [3:0]       flags_q, flags_d;
    logic             neg_q, neg_d;
    logic             adds_q, adds_d;
    logic             via_scr_q, via_scr_d;

    // Registered outputs
    logic [31:0]      instr_q, instr_d;
    logic             mux_ctrl_q, mux_ctrl_d;
    logic             mul_release_q, mul_release_d;
    logic [3:0]       flags_back_q, flags_back_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    // Multiplier decode helpers
    logic [CNT_W-1:0] imm_ext;
    logic [CNT_W-1:0] mult_val;
    logic [CNT_W-1:0] mult_mag;
    logic             mult_neg;

    // Builds the micro-op a given state emits; idle and halt emit the NOP
    function automatic logic [31:0] encode(
        input state_t           st,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rn,
        input logic             via_scr,
        input logic             use_adds
    );
        logic [3:0] d;
        logic [3:0] s;
        logic [3:0] e;
        logic [6:0] add_op;
        d      = 4'(rd);
        s      = 4'(rn);
        e      = via_scr ? SCR_FLD : s;
        add_op = use_adds ? OP_ADDS : OP_ADD;
        case (st)
            S_CLEAR:   encode = {OP_SUB, d, d, d, 13'b0};
            S_COPY0:   encode = {OP_SUB, SCR_FLD, SCR_FLD, SCR_FLD, 13'b0};
            S_COPY1:   encode = {OP_ADD, SCR_FLD, SCR_FLD, s, 13'b0};
            S_MOV:     encode = {OP_MOV, d, 5'b0, 16'b0};
            S_ADD:     encode = {add_op, d, d, e, 13'b0};
            S_FIX_SUB: encode = {OP_SUBI, d, d, 1'b0, 16'd1};
            S_FIX_NOT: encode = {OP_NOT, d, d, 17'b0};
            default:   encode = NOP_INSTR;
        endcase
    endfunction

    // Next state, operand capture and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        src_d     = src_q;
        flags_d   = flags_q;
        neg_d     = neg_q;
        adds_d    = adds_q;
        via_scr_d = via_scr_q;

        imm_ext  = CNT_W'($signed(immediate));
        mult_val = mul_type[0] ? readDataSecond : imm_ext;
        mult_neg = mult_val[CNT_W-1];
        // The most negative value maps onto itself, which read unsigned is its magnitude
        mult_mag = mult_neg ? (~mult_val + CNT_W'(1)) : mult_val;

        if (flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_mul) begin
                        cnt_d     = mult_mag;
                        dest_d    = dest_reg;
                        src_d     = source_reg;
                        flags_d   = flags_in;
                        neg_d     = mult_neg;
                        adds_d    = mul_type[1];
                        via_scr_d = (dest_reg == source_reg);
                        if (mult_mag == '0) begin
                            state_d = S_CLEAR;
                        end else if (dest_reg == source_reg) begin
                            state_d = S_COPY0;
                        end else begin
                            state_d = S_MOV;
                        end
                    end
                end
                S_CLEAR:   if (!stall) state_d = S_HALT;
                S_COPY0:   if (!stall) state_d = S_COPY1;
                S_COPY1:   if (!stall) state_d = S_MOV;
                S_MOV:     if (!stall) state_d = S_ADD;
                S_ADD: begin
                    if (!stall) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = neg_q ? S_FIX_SUB : S_HALT;
                        end
                    end
                end
                S_FIX_SUB: if (!stall) state_d = S_FIX_NOT;
                S_FIX_NOT: if (!stall) state_d = S_HALT;
                S_HALT:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end

        // Outputs are registered against the state being entered
        instr_d       = encode(state_d, dest_d, src_d, via_scr_d, adds_d);
        mux_ctrl_d    = (state_d != S_IDLE) && (state_d != S_HALT);
        mul_release_d = (state_d == S_HALT);
        flags_back_d  = (state_d == S_HALT) ? flags_d : flags_back_q;
        ready_d       = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE);
    end

    // State, captured operands and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            dest_q        <= '0;
            src_q         <= '0;
            flags_q       <= '0;
            neg_q         <= 1'b0;
            adds_q        <= 1'b0;
            via_scr_q     <= 1'b0;
            instr_q       <= NOP_INSTR;
            mux_ctrl_q    <= 1'b0;
            mul_release_q <= 1'b0;
            flags_back_q  <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dest_q        <= dest_d;
            src_q         <= src_d;
            flags_q       <= flags_d;
            neg_q         <= neg_d;
            adds_q        <= adds_d;
            via_scr_q     <= via_scr_d;
            instr_q       <= instr_d;
            mux_ctrl_q    <= mux_ctrl_d;
            mul_release_q <= mul_release_d;
            flags_back_q  <= flags_back_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    assign output_instruction = instr_q;
    assign mux_ctrl           = mux_ctrl_q;
    assign mul_release        = mul_release_q;
    assign flags_back_out     = flags_back_q;
    assign mul_ready          = ready_q;
    assign busy               = busy_q;

endmodule
